// File: rtl/mac_sequencer.sv
// Sequences one fixed-latency multiply-add unit through an N-term dot product.
// It fetches operand pairs, feeds each pair with the running sum, and pulses the final sum out.
module mac_sequencer #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned MAC_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  macSeqRst,
    input  logic                  start,
    input  logic                  clear,
    input  logic [CNT_WIDTH-1:0]  termCount,
    input  logic [ADDR_WIDTH-1:0] dataBase,
    input  logic [ADDR_WIDTH-1:0] weightBase,
    output logic                  rdEn,
    output logic [ADDR_WIDTH-1:0] dataAddr,
    output logic [ADDR_WIDTH-1:0] weightAddr,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic [DATA_WIDTH-1:0] weightIn,
    output logic                  macEn,
    output logic [DATA_WIDTH-1:0] macData,
    output logic [DATA_WIDTH-1:0] macWeight,
    output logic [DATA_WIDTH-1:0] macSum,
    input  logic [DATA_WIDTH-1:0] macResult,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  resultValid
);
    localparam int unsigned WaitW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MAC_LATENCY - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StExec  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  term_m1_q;
    logic [CNT_WIDTH-1:0]  idx_q;
    logic [WaitW-1:0]      wait_cnt_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [ADDR_WIDTH-1:0] data_addr_q, weight_addr_q;
    logic [DATA_WIDTH-1:0] mac_data_q, mac_weight_q, mac_sum_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  last_wait, last_term, first_exec;

    assign last_wait  = (wait_cnt_q == WaitLast);
    // Comparing against N-1 latched at start keeps idx below N, so it never overflows.
    assign last_term  = (idx_q == term_m1_q);
    assign first_exec = (state_q == StExec) && (wait_cnt_q == '0);

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start) state_d = (termCount == '0) ? StDone : StFetch;
                StFetch: state_d = StExec;
                StExec:  if (last_wait) state_d = last_term ? StDone : StFetch;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge macSeqRst) begin
        if (macSeqRst) begin
            state_q       <= StIdle;
            term_m1_q     <= '0;
            idx_q         <= '0;
            wait_cnt_q    <= '0;
            acc_q         <= '0;
            data_addr_q   <= '0;
            weight_addr_q <= '0;
            mac_data_q    <= '0;
            mac_weight_q  <= '0;
            mac_sum_q     <= '0;
            result_q      <= '0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                acc_q      <= '0;
                idx_q      <= '0;
                wait_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            idx_q         <= '0;
                            acc_q         <= '0;
                            term_m1_q     <= termCount - CNT_WIDTH'(1);
                            data_addr_q   <= dataBase;
                            weight_addr_q <= weightBase;
                            if (termCount == '0) result_q <= '0;
                        end
                    end
                    StFetch: wait_cnt_q <= '0;
                    StExec: begin
                        if (wait_cnt_q == '0) begin
                            mac_data_q   <= dataIn;
                            mac_weight_q <= weightIn;
                            mac_sum_q    <= acc_q;
                        end
                        wait_cnt_q <= wait_cnt_q + WaitW'(1);
                        if (last_wait) begin
                            acc_q <= macResult;
                            // Result loads on entry to DONE so it is valid alongside the pulse.
                            if (last_term) begin
                                result_q <= macResult;
                            end else begin
                                idx_q         <= idx_q + CNT_WIDTH'(1);
                                data_addr_q   <= data_addr_q + ADDR_WIDTH'(1);
                                weight_addr_q <= weight_addr_q + ADDR_WIDTH'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rdEn        = (state_q == StFetch);
    assign macEn       = (state_q == StExec);
    assign busy        = (state_q != StIdle);
    assign resultValid = (state_q == StDone) && !clear;
    assign dataAddr    = data_addr_q;
    assign weightAddr  = weight_addr_q;
    assign result      = result_q;

    // Read data arrives in the first EXEC cycle; pass it straight through, then hold the copy.
    assign macData   = first_exec ? dataIn   : mac_data_q;
    assign macWeight = first_exec ? weightIn : mac_weight_q;
    assign macSum    = first_exec ? acc_q    : mac_sum_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: buffer and 3-cycle MAC models around the DUT, with a
// reference dot product computed by folding real-valued multiply-adds over the buffers.
module tb_mac_sequencer;
    logic        clk = 1'b0;
    logic        macSeqRst;
    logic        start, clear;
    logic [15:0] termCount;
    logic [9:0]  dataBase, weightBase;
    logic        rdEn;
    logic [9:0]  dataAddr, weightAddr;
    logic [31:0] dataIn, weightIn;
    logic        macEn;
    logic [31:0] macData, macWeight, macSum, macResult;
    logic        busy;
    logic [31:0] result;
    logic        resultValid;

    int checks = 0;
    int errors = 0;

    logic [31:0] dmem [1024];
    logic [31:0] wmem [1024];
    logic [31:0] pipe1, pipe2;
    logic [31:0] last_result;

    always #5 clk = ~clk;

    mac_sequencer #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (10),
        .CNT_WIDTH  (16),
        .MAC_LATENCY(3)
    ) dut (
        .clk        (clk),
        .macSeqRst  (macSeqRst),
        .start      (start),
        .clear      (clear),
        .termCount  (termCount),
        .dataBase   (dataBase),
        .weightBase (weightBase),
        .rdEn       (rdEn),
        .dataAddr   (dataAddr),
        .weightAddr (weightAddr),
        .dataIn     (dataIn),
        .weightIn   (weightIn),
        .macEn      (macEn),
        .macData    (macData),
        .macWeight  (macWeight),
        .macSum     (macSum),
        .macResult  (macResult),
        .busy       (busy),
        .result     (result),
        .resultValid(resultValid)
    );

    // Single-precision <-> real conversion for normal numbers and zero.
    function automatic real f2r(input logic [31:0] b);
        logic [10:0] e;
        if (b[30:23] == 8'd0) return 0.0;
        e = {3'b0, b[30:23]} - 11'd127 + 11'd1023;
        return $bitstoreal({b[31], e, b[22:0], 29'b0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'b0};
        e = d[62:52] - 11'd1023 + 11'd127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] mac_f(input logic [31:0] d, input logic [31:0] w,
                                          input logic [31:0] s);
        return r2f(f2r(d) * f2r(w) + f2r(s));
    endfunction

    // Synchronous-read buffers: data valid one cycle after rdEn.
    always @(posedge clk) begin
        if (rdEn) begin
            dataIn   <= dmem[dataAddr];
            weightIn <= wmem[weightAddr];
        end
    end

    // MAC model: result valid in the third cycle of operand presentation; idle clears it.
    always @(posedge clk) begin
        if (!macEn) begin
            pipe1 <= 32'd0;
            pipe2 <= 32'd0;
        end else begin
            pipe1 <= mac_f(macData, macWeight, macSum);
            pipe2 <= pipe1;
        end
    end
    assign macResult = pipe2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One dot product from start; restart_at>0 re-pulses start (N=7) at that busy cycle.
    task automatic run_dot(input int n, input logic [9:0] db, input logic [9:0] wb,
                           input int restart_at, input string tag);
        logic [31:0] exp_sum, got;
        logic [9:0]  dq[$];
        logic [9:0]  wq[$];
        logic [9:0]  ea;
        int exp_lat, valid_cnt, valid_at, mac_cnt, busy_bad;
        exp_sum = 32'd0;
        for (int i = 0; i < n; i++) begin
            exp_sum = mac_f(dmem[(int'(db) + i) % 1024], wmem[(int'(wb) + i) % 1024], exp_sum);
        end
        exp_lat   = (n == 0) ? 1 : n * 4 + 1;
        valid_cnt = 0;
        valid_at  = -1;
        mac_cnt   = 0;
        busy_bad  = 0;
        got       = 32'hx;
        @(negedge clk);
        start = 1'b1;
        termCount = 16'(n);
        dataBase = db;
        weightBase = wb;
        for (int k = 1; k <= exp_lat + 3; k++) begin
            @(negedge clk);
            start = (k == restart_at);
            termCount = (k == restart_at) ? 16'd7 : 16'(n);
            if (rdEn) begin
                dq.push_back(dataAddr);
                wq.push_back(weightAddr);
            end
            if (macEn) mac_cnt++;
            if (resultValid) begin
                valid_cnt++;
                valid_at = k;
                got = result;
            end
            if (busy !== (k <= exp_lat)) busy_bad++;
        end
        start = 1'b0;
        check({tag, " valid_pulses"}, 64'(valid_cnt), 64'd1);
        check({tag, " valid_cycle"}, 64'(valid_at), 64'(exp_lat));
        check({tag, " result"}, 64'(got), 64'(exp_sum));
        check({tag, " result_held"}, 64'(result), 64'(exp_sum));
        check({tag, " busy_profile"}, 64'(busy_bad), 64'd0);
        check({tag, " reads"}, 64'(dq.size()), 64'(n));
        check({tag, " mac_cycles"}, 64'(mac_cnt), 64'(n * 3));
        for (int i = 0; i < n && i < dq.size(); i++) begin
            ea = db + 10'(i);
            check({tag, " data_addr"}, 64'(dq[i]), 64'(ea));
            ea = wb + 10'(i);
            check({tag, " weight_addr"}, 64'(wq[i]), 64'(ea));
        end
        last_result = exp_sum;
    endtask

    initial begin
        int vcnt;
        macSeqRst = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        termCount = 16'd0;
        dataBase = 10'd0;
        weightBase = 10'd0;
        dataIn = 32'd0;
        weightIn = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            dmem[i] = r2f(real'($urandom_range(0, 7)));
            wmem[i] = r2f(real'($urandom_range(0, 7)));
        end
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset rdEn", 64'(rdEn), 64'd0);
        check("reset macEn", 64'(macEn), 64'd0);
        check("reset resultValid", 64'(resultValid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset dataAddr", 64'(dataAddr), 64'd0);
        check("reset macSum", 64'(macSum), 64'd0);
        macSeqRst = 1'b0;
        @(negedge clk);

        // 1*2 + 2*2 + 3*2 = 12.0
        dmem[10] = 32'h3F80_0000; dmem[11] = 32'h4000_0000; dmem[12] = 32'h4040_0000;
        wmem[20] = 32'h4000_0000; wmem[21] = 32'h4000_0000; wmem[22] = 32'h4000_0000;
        run_dot(3, 10'd10, 10'd20, 0, "n3");
        check("n3 twelve", 64'(last_result), 64'h4140_0000);

        dmem[10'h3FF] = 32'h4040_0000;
        wmem[10'h3FF] = 32'h4040_0000;
        run_dot(1, 10'h3FF, 10'h3FF, 0, "n1_top");
        check("n1 nine", 64'(last_result), 64'h4110_0000);

        run_dot(2, 10'h3FE, 10'h3FE, 0, "n2_edge");
        run_dot(3, 10'h3FF, 10'h3FF, 0, "n3_wrap");
        run_dot(0, 10'd5, 10'd5, 0, "n0");
        run_dot(2, 10'd40, 10'd50, 3, "restart");

        // Clear during the second EXEC of an N=4 run.
        dmem[100] = 32'h4000_0000;
        wmem[200] = 32'h4000_0000;
        @(negedge clk);
        start = 1'b1;
        termCount = 16'd4;
        dataBase = 10'd100;
        weightBase = 10'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("clear in_exec", 64'(macEn), 64'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear busy", 64'(busy), 64'd0);
        check("clear macEn", 64'(macEn), 64'd0);
        check("clear rdEn", 64'(rdEn), 64'd0);
        check("clear result", 64'(result), 64'(last_result));
        vcnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (resultValid) vcnt++;
            @(negedge clk);
        end
        check("clear no_valid", 64'(vcnt), 64'd0);
        run_dot(2, 10'd7, 10'd9, 0, "after_clear");

        for (int r = 0; r < 8; r++) begin
            run_dot(int'($urandom_range(1, 6)), 10'($urandom_range(0, 1023)),
                    10'($urandom_range(0, 1023)), 0, "random");
        end

        // Asynchronous reset in the middle of EXEC.
        @(negedge clk);
        start = 1'b1;
        termCount = 16'd3;
        dataBase = 10'd300;
        weightBase = 10'd400;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("prereset in_exec", 64'(macEn), 64'd1);
        #2 macSeqRst = 1'b1;
        #1;
        check("async busy", 64'(busy), 64'd0);
        check("async macEn", 64'(macEn), 64'd0);
        check("async rdEn", 64'(rdEn), 64'd0);
        check("async resultValid", 64'(resultValid), 64'd0);
        check("async result", 64'(result), 64'd0);
        check("async macData", 64'(macData), 64'd0);
        check("async macSum", 64'(macSum), 64'd0);
        check("async dataAddr", 64'(dataAddr), 64'd0);
        @(negedge clk);
        macSeqRst = 1'b0;
        run_dot(2, 10'd600, 10'd700, 0, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
